// File: rtl/line_buf_pkg.sv
// Shared definitions for the vertical-window line buffer: the border policy
// encodings, counter width helpers and tap slice placement.
package line_buf_pkg;

  // Top-border policy applied while fewer than KSIZE-1 complete lines are stored
  typedef enum logic [1:0] {
    PAD_SUPPRESS  = 2'd0,
    PAD_ZERO      = 2'd1,
    PAD_REPLICATE = 2'd2
  } pad_mode_e;

  // Allowed window heights
  localparam int KSIZE_MIN = 2;
  localparam int KSIZE_MAX = 7;

  // Bits needed to count 0..n-1; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of tap idx inside the flattened column bus
  function automatic int tap_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage. The pre-write content at addr is always visible
// on rdata_old, so a write in the same cycle never disturbs what is read
// (read-first); the write itself happens on the clock edge.
module line_ram
  import line_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 480,
  localparam int AW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_old
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_old = mem_q[addr];

  // Storage is deliberately left uninitialised; the fill counter upstream masks stale lines
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Vertical-window line buffer. Every accepted pixel produces, one cycle later,
// a column of KSIZE pixels at the same column: slice 0 is the current row,
// slice KSIZE-1 the oldest. KSIZE-1 line RAMs share the column address and
// shift each column down one line per accepted pixel. Rows not yet filled in
// the current frame are suppressed, zeroed or replicated per PAD_MODE.
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int KSIZE      = 3,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272,
  parameter int PAD_MODE   = 0,
  localparam int CW = cnt_w(PIC_WIDTH),
  localparam int RW = cnt_w(PIC_HEIGHT),
  localparam int FW = cnt_w(KSIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sof,
  input  logic [WIDTH-1:0]       din,
  input  logic                   valid_in,
  output logic [WIDTH*KSIZE-1:0] taps_out,
  output logic                   valid_out,
  output logic [CW-1:0]          col_out,
  output logic [RW-1:0]          row_out,
  output logic                   frame_done
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] fill_q, fill_d;

  logic [KSIZE-1:0][WIDTH-1:0] taps_q, taps_d;
  logic [CW-1:0] col_out_q, col_out_d;
  logic [RW-1:0] row_out_q, row_out_d;
  logic          valid_out_q, valid_out_d;
  logic          frame_done_q, frame_done_d;

  // Position of the pixel on din this cycle; sof restarts it at the origin
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [FW-1:0] cur_fill;
  logic          last_col;
  logic          last_row;
  logic          ram_we;

  // raw[0] is the incoming pixel, raw[i] the old content of line RAM i at cur_col
  logic [KSIZE-1:0][WIDTH-1:0] raw;
  logic [WIDTH-1:0]            repl;

  assign raw[0] = din;

  for (genvar i = 1; i < KSIZE; i++) begin : g_line
    line_ram #(
      .WIDTH (WIDTH),
      .DEPTH (PIC_WIDTH)
    ) u_line_ram (
      .clk       (clk),
      .we        (ram_we),
      .addr      (cur_col),
      .wdata     (raw[i-1]),
      .rdata_old (raw[i])
    );
  end

  // Column/row/fill bookkeeping: advance on acceptance, wrap at line and frame ends
  always_comb begin
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    cur_fill = sof ? '0 : fill_q;
    last_col = (cur_col == CW'(PIC_WIDTH - 1));
    last_row = (cur_row == RW'(PIC_HEIGHT - 1));
    ram_we   = rst_n && valid_in;

    col_d  = col_q;
    row_d  = row_q;
    fill_d = fill_q;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d  = '0;
          fill_d = '0;
        end else begin
          row_d  = cur_row + RW'(1);
          fill_d = (cur_fill == FW'(KSIZE - 1)) ? cur_fill : cur_fill + FW'(1);
        end
      end else begin
        col_d  = cur_col + CW'(1);
        row_d  = cur_row;
        fill_d = cur_fill;
      end
    end else if (sof) begin
      col_d  = '0;
      row_d  = '0;
      fill_d = '0;
    end
  end

  // Output stage: border policy applied to the column, everything held during gaps
  always_comb begin
    repl         = raw[cur_fill];
    taps_d       = taps_q;
    col_out_d    = col_out_q;
    row_out_d    = row_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (valid_in) begin
      for (int i = 0; i < KSIZE; i++) begin
        if (i > int'(cur_fill)) begin
          if (PAD_MODE == int'(PAD_ZERO)) begin
            taps_d[i] = '0;
          end else if (PAD_MODE == int'(PAD_REPLICATE)) begin
            taps_d[i] = repl;
          end else begin
            taps_d[i] = raw[i];
          end
        end else begin
          taps_d[i] = raw[i];
        end
      end
      col_out_d    = cur_col;
      row_out_d    = cur_row;
      valid_out_d  = (PAD_MODE != int'(PAD_SUPPRESS)) || (cur_fill == FW'(KSIZE - 1));
      frame_done_d = last_col && last_row;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      fill_q       <= '0;
      taps_q       <= '0;
      col_out_q    <= '0;
      row_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      fill_q       <= fill_d;
      taps_q       <= taps_d;
      col_out_q    <= col_out_d;
      row_out_q    <= row_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Flatten the column with tap 0 in the LSBs
  always_comb begin
    taps_out = '0;
    for (int i = 0; i < KSIZE; i++) begin
      taps_out[tap_lsb(i, WIDTH) +: WIDTH] = taps_q[i];
    end
  end

  assign valid_out  = valid_out_q;
  assign col_out    = col_out_q;
  assign row_out    = row_out_q;
  assign frame_done = frame_done_q;

endmodule
